// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one uart_tx byte transmitter
// among N_REQ byte-stream requesters, with an optional stall timeout.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic [7:0]         data_o,
  output logic               start_o,
  input  logic               done_i,
  output logic               busy_o,
  output logic               timeout_o
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LIM   = CW'(TIMEOUT);
  localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);

  typedef enum logic [2:0] {ARB, FETCH, SEND, WAIT_LO, WAIT_HI} state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_grant;
  logic [PW-1:0]    r_gidx;
  logic [PW-1:0]    r_rr_ptr;
  logic [7:0]       r_data;
  logic             r_last;
  logic             r_timeout;
  logic [CW-1:0]    r_stall;

  logic [7:0]       w_bytes [N_REQ];
  logic             w_found;
  logic [PW-1:0]    w_sel;
  logic [PW-1:0]    w_next_ptr;
  logic [CW-1:0]    w_stall_inc;
  logic             w_g_valid;
  logic             w_g_last;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
      assign w_bytes[gi] = req_data_i[8*gi +: 8];
    end
  endgenerate

  // Scan downward so the last hit is the first valid requester at or after rr_ptr.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[(int'(r_rr_ptr) + k) % N_REQ]) begin
        w_found = 1'b1;
        w_sel   = PW'((int'(r_rr_ptr) + k) % N_REQ);
      end
    end
  end

  assign w_next_ptr  = (r_gidx == LAST_IDX) ? '0 : r_gidx + PW'(1);
  assign w_stall_inc = r_stall + CW'(1);
  assign w_g_valid   = req_valid_i[r_gidx];
  assign w_g_last    = req_last_i[r_gidx];

  assign req_ready_o = (r_state == FETCH) ? r_grant : '0;
  assign start_o     = (r_state == SEND) && done_i;
  assign busy_o      = |r_grant;
  assign grant_o     = r_grant;
  assign data_o      = r_data;
  assign timeout_o   = r_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB;
      r_grant   <= '0;
      r_gidx    <= '0;
      r_rr_ptr  <= '0;
      r_data    <= '0;
      r_last    <= 1'b0;
      r_timeout <= 1'b0;
      r_stall   <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ARB: begin
          if (w_found) begin
            r_grant <= N_REQ'(1) << w_sel;
            r_gidx  <= w_sel;
            r_stall <= '0;
            r_state <= FETCH;
          end
        end
        FETCH: begin
          if (w_g_valid) begin
            r_data  <= w_bytes[r_gidx];
            r_last  <= w_g_last;
            r_stall <= '0;
            r_state <= SEND;
          end else if (TIMEOUT != 0) begin
            // The lock is dropped on the cycle the stall count reaches TIMEOUT.
            if (w_stall_inc == TO_LIM) begin
              r_timeout <= 1'b1;
              r_grant   <= '0;
              r_rr_ptr  <= w_next_ptr;
              r_stall   <= '0;
              r_state   <= ARB;
            end else begin
              r_stall <= w_stall_inc;
            end
          end
        end
        SEND: begin
          if (done_i) r_state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!done_i) r_state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (done_i) begin
            if (r_last) begin
              r_grant  <= '0;
              r_rr_ptr <= w_next_ptr;
              r_state  <= ARB;
            end else begin
              r_state <= FETCH;
            end
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

endmodule
